retire_trace_tx: RTL and testbench
==================================

Name: retire_trace_tx

Overview:
- Synthesizable retire-trace transmitter for the pipelined CPU.
- Captures one retire event per cycle from the writeback stage: PC, register write, load, store, halt, or NOP/branch.
- Buffers events in a record FIFO and serializes each as a variable-length burst of 16-bit words on a valid/ready stream.
- The off-chip or bench-side collector rebuilds the instruction trace (INUM/PC/REG/ADDR/VALUE) from the stream without probing internal signals.

Parameters:
- DEPTH, 8, record FIFO entries (power of 2, ≥2).
- DROP_W, 8, width of saturating dropped-event counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ret_valid  in  1  one instruction retires this cycle
- ret_pc  in  16  PC of retiring instruction
- ret_reg_we  in  1  register file write
- ret_rd  in  4  destination register
- ret_wdata  in  16  register write data
- ret_mem_re  in  1  memory read
- ret_mem_we  in  1  memory write
- ret_addr  in  16  memory address
- ret_mdata  in  16  store data
- ret_halt  in  1  HLT retiring
- tr_valid  out  1  stream word valid
- tr_data  out  16  stream word
- tr_last  out  1  final word of record
- tr_ready  in  1  consumer accepts word
- overflow  out  1  sticky: at least one event dropped
- drop_cnt  out  DROP_W  dropped events, saturating
- fifo_level  out  $clog2(DEPTH)+1  occupied entries
- trace_done  out  1  HALT record fully transmitted

Behaviour:
- Reset (rst_n=0 at posedge): tr_valid=0, tr_data=0, tr_last=0, overflow=0, drop_cnt=0, fifo_level=0, trace_done=0. Event index inum=0, FIFO empty, serializer in IDLE, halt_seen=0.
- Classification at capture, highest priority first:
  - HALT(4): ret_halt
  - STORE(3): ret_mem_we
  - LOAD(2): ret_reg_we & ret_mem_re
  - REG(1): ret_reg_we
  - NOP(0): otherwise
- Header word = {type[2:0], rd[3:0], inum[8:0]}. rd is 0 for NOP/STORE/HALT. inum wraps mod 512.
- Record words, in order:
  - NOP: header, PC (2 words)
  - REG: header, PC, wdata (3)
  - LOAD: header, PC, wdata, addr (4)
  - STORE: header, PC, addr, mdata (4)
  - HALT: header, PC (2)
- Capture: on posedge with ret_valid=1 and halt_seen=0:
  - inum increments whether or not the event is stored, so drops appear as gaps.
  - The event is pushed if fifo_level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise it is dropped: overflow←1, drop_cnt+1 saturating at all-ones.
- HALT capture: sets halt_seen=1. Later ret_valid events are ignored, with no inum change and no drop count. A dropped HALT still sets halt_seen; trace_done then never asserts (bench must check overflow).
- Serializer FSM states:
  - IDLE → HDR when FIFO non-empty.
  - HDR → PC → P0 → P1, advancing one state per tr_valid&tr_ready handshake.
  - NOP/HALT finish at PC, REG at P0, LOAD/STORE at P1.
  - On the last-word handshake the entry is popped. Next state is HDR if FIFO is still non-empty (back-to-back records, no bubble), else IDLE.
- Stream rules:
  - tr_valid=1 in every state except IDLE.
  - tr_data and tr_last hold stable while tr_valid & ~tr_ready.
  - tr_last=1 only on the record's final word.
  - tr_valid never drops without a handshake.
- Latency: an event captured at edge N into an empty FIFO with the serializer IDLE gives tr_valid=1 with the header after edge N+1 (registered output). Full throughput is one word per cycle under continuous tr_ready.
- fifo_level reflects registered occupancy: +1 push, −1 pop, unchanged if both occur.
- trace_done←1 after the HALT record's last-word handshake and stays 1 until reset.
- Reset mid-record: the record is abandoned and all state cleared; no partial word is emitted after reset.

Test Plan:
- REG retire PC=0x0004, rd=3, wdata=0x00AB, tr_ready=1 → words 0x2600, 0x0004, 0x00AB (tr_last on 3rd); rd=3 gives header 0x2600 with inum=0.
- LOAD (reg_we, mem_re, rd=5, wdata=0x1234, addr=0x0040) as inum=1 → 0x4A01, PC, 0x1234, 0x0040; tr_last on 4th word.
- STORE addr=0x0010 mdata=0xBEEF, tr_ready toggled 1/0 every cycle → 0x6000|inum, PC, 0x0010, 0xBEEF; data stable during stalls; no duplicated or lost words.
- DEPTH=8, tr_ready=0, 10 consecutive NOP retires → fifo_level=8, overflow=1, drop_cnt=2. Release tr_ready → 8 two-word records with inum 0..7.
- HALT at PC=0x0020 followed by 3 more ret_valid → only the HALT record (0x8000|inum, 0x0020) is emitted, trace_done=1 after its tr_last handshake, inum frozen.
- rst_n=0 asserted during word 2 of a LOAD record → next cycle all outputs 0. A new REG event afterwards starts at inum=0.

Source files
------------

// File: rtl/retire_trace_tx.sv
// Retire-trace transmitter: classifies each retiring instruction, queues it as a
// record and streams it out as a 2..4 word burst of 16-bit words on valid/ready.
module retire_trace_tx #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ret_valid,
    input  logic [15:0]            ret_pc,
    input  logic                   ret_reg_we,
    input  logic [3:0]             ret_rd,
    input  logic [15:0]            ret_wdata,
    input  logic                   ret_mem_re,
    input  logic                   ret_mem_we,
    input  logic [15:0]            ret_addr,
    input  logic [15:0]            ret_mdata,
    input  logic                   ret_halt,
    output logic                   tr_valid,
    output logic [15:0]            tr_data,
    output logic                   tr_last,
    input  logic                   tr_ready,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   trace_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] T_NOP   = 3'd0;
    localparam logic [2:0] T_REG   = 3'd1;
    localparam logic [2:0] T_LOAD  = 3'd2;
    localparam logic [2:0] T_STORE = 3'd3;
    localparam logic [2:0] T_HALT  = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PC, S_P0, S_P1} state_t;

    // Each entry holds {word3, word2, pc, header} plus the index of its final word.
    logic [63:0] rec_mem   [DEPTH];
    logic [1:0]  lastw_mem [DEPTH];

    state_t            state_reg, state_next;
    logic [15:0]       data_reg, data_next;
    logic              last_reg, last_next;
    logic              done_reg, done_next;
    logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [8:0]        inum_reg;
    logic              halt_seen_reg;
    logic              overflow_reg;
    logic [DROP_W-1:0] drop_reg;

    logic [2:0]  ev_type;
    logic [3:0]  ev_rd;
    logic [15:0] ev_w2, ev_w3, ev_hdr;
    logic [1:0]  ev_last;
    logic        capture, push, pop, drop;
    logic [1:0]  cur_idx, nxt_idx, cur_last;
    logic [63:0] cur_rec;
    logic [15:0] cur_word [4];
    logic [15:0] nxt_hdr;

    always_comb begin
        ev_type = T_NOP;
        ev_rd   = 4'd0;
        ev_w2   = 16'd0;
        ev_w3   = 16'd0;
        ev_last = 2'd1;
        if (ret_halt) begin
            ev_type = T_HALT;
        end else if (ret_mem_we) begin
            ev_type = T_STORE;
            ev_w2   = ret_addr;
            ev_w3   = ret_mdata;
            ev_last = 2'd3;
        end else if (ret_reg_we && ret_mem_re) begin
            ev_type = T_LOAD;
            ev_rd   = ret_rd;
            ev_w2   = ret_wdata;
            ev_w3   = ret_addr;
            ev_last = 2'd3;
        end else if (ret_reg_we) begin
            ev_type = T_REG;
            ev_rd   = ret_rd;
            ev_w2   = ret_wdata;
            ev_last = 2'd2;
        end
    end

    assign ev_hdr = {ev_type, ev_rd, inum_reg};

    assign cur_rec  = rec_mem[rd_ptr_reg];
    assign cur_last = lastw_mem[rd_ptr_reg];
    assign nxt_hdr  = rec_mem[rd_ptr_reg + AW'(1)][15:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign cur_word[gi] = cur_rec[16*gi +: 16];
        end
    endgenerate

    always_comb begin
        cur_idx = 2'd0;
        case (state_reg)
            S_PC:    cur_idx = 2'd1;
            S_P0:    cur_idx = 2'd2;
            S_P1:    cur_idx = 2'd3;
            default: cur_idx = 2'd0;
        endcase
    end

    assign nxt_idx = cur_idx + 2'd1;
    assign tr_valid = (state_reg != S_IDLE);
    assign pop      = tr_valid & tr_ready & (cur_idx == cur_last);

    // Inum still advances on a drop so the collector sees a gap.
    assign capture = ret_valid & ~halt_seen_reg;
    assign push    = capture & ((count_reg < CW'(DEPTH)) | pop);
    assign drop    = capture & ~push;

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        last_next  = last_reg;
        done_next  = done_reg;
        if (state_reg == S_IDLE) begin
            if (count_reg != '0) begin
                state_next = S_HDR;
                data_next  = cur_word[0];
                last_next  = 1'b0;
            end
        end else if (tr_ready) begin
            if (pop) begin
                if (cur_word[0][15:13] == T_HALT) begin
                    done_next = 1'b1;
                end
                // A record arriving into an otherwise drained FIFO is bypassed
                // straight to the output so back-to-back bursts have no bubble.
                if (count_reg > CW'(1)) begin
                    state_next = S_HDR;
                    data_next  = nxt_hdr;
                    last_next  = 1'b0;
                end else if (push) begin
                    state_next = S_HDR;
                    data_next  = ev_hdr;
                    last_next  = 1'b0;
                end else begin
                    state_next = S_IDLE;
                    data_next  = 16'd0;
                    last_next  = 1'b0;
                end
            end else begin
                case (nxt_idx)
                    2'd1:    state_next = S_PC;
                    2'd2:    state_next = S_P0;
                    default: state_next = S_P1;
                endcase
                data_next = cur_word[nxt_idx];
                last_next = (nxt_idx == cur_last);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            data_reg      <= 16'd0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            inum_reg      <= 9'd0;
            halt_seen_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            drop_reg      <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            last_reg  <= last_next;
            done_reg  <= done_next;
            count_reg <= count_reg + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (capture) begin
                inum_reg <= inum_reg + 9'd1;
                if (ret_halt) begin
                    halt_seen_reg <= 1'b1;
                end
            end
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_reg != '1) begin
                    drop_reg <= drop_reg + DROP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rec_mem[wr_ptr_reg]   <= {ev_w3, ev_w2, ret_pc, ev_hdr};
            lastw_mem[wr_ptr_reg] <= ev_last;
        end
    end

    assign tr_data    = data_reg;
    assign tr_last    = last_reg;
    assign overflow   = overflow_reg;
    assign drop_cnt   = drop_reg;
    assign fifo_level = count_reg;
    assign trace_done = done_reg;

endmodule

// File: tb/tb_retire_trace_tx.sv
// Self-checking bench for retire_trace_tx: directed vector table, corner-case
// sequences and randomized traffic checked against a record-level reference model.
module tb_retire_trace_tx;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ret_valid;
    logic [15:0]       ret_pc;
    logic              ret_reg_we;
    logic [3:0]        ret_rd;
    logic [15:0]       ret_wdata;
    logic              ret_mem_re;
    logic              ret_mem_we;
    logic [15:0]       ret_addr;
    logic [15:0]       ret_mdata;
    logic              ret_halt;
    logic              tr_valid;
    logic [15:0]       tr_data;
    logic              tr_last;
    logic              tr_ready;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    logic [$clog2(DEPTH):0] fifo_level;
    logic              trace_done;

    always #5 clk = ~clk;

    retire_trace_tx #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_reg_we(ret_reg_we), .ret_rd(ret_rd), .ret_wdata(ret_wdata),
        .ret_mem_re(ret_mem_re), .ret_mem_we(ret_mem_we), .ret_addr(ret_addr),
        .ret_mdata(ret_mdata), .ret_halt(ret_halt), .tr_valid(tr_valid),
        .tr_data(tr_data), .tr_last(tr_last), .tr_ready(tr_ready),
        .overflow(overflow), .drop_cnt(drop_cnt), .fifo_level(fifo_level),
        .trace_done(trace_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { logic [15:0] w; logic last; logic halt_end; } exp_t;
    typedef struct { logic [15:0] w; logic last; } got_t;
    exp_t exp_q[$];
    got_t got_q[$];

    int   m_occ = 0, m_inum = 0, m_drops = 0;
    logic m_halt = 1'b0, m_ovf = 1'b0, m_done = 1'b0, m_on = 1'b0;
    logic stall_prev = 1'b0, stall_last = 1'b0;
    logic [15:0] stall_data = 16'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: a retire event becomes a list of expected words from the record rules.
    function automatic void model_capture();
        logic [2:0]  t;
        logic [3:0]  rd;
        logic [15:0] w [4];
        int n;
        if (ret_halt) t = 3'd4;
        else if (ret_mem_we) t = 3'd3;
        else if (ret_reg_we && ret_mem_re) t = 3'd2;
        else if (ret_reg_we) t = 3'd1;
        else t = 3'd0;
        rd = (t == 3'd1 || t == 3'd2) ? ret_rd : 4'd0;
        w[0] = {t, rd, 9'(m_inum % 512)};
        w[1] = ret_pc;
        w[2] = 16'd0;
        w[3] = 16'd0;
        n = 2;
        if (t == 3'd1) begin w[2] = ret_wdata; n = 3; end
        if (t == 3'd2) begin w[2] = ret_wdata; w[3] = ret_addr; n = 4; end
        if (t == 3'd3) begin w[2] = ret_addr; w[3] = ret_mdata; n = 4; end
        for (int i = 0; i < n; i++)
            exp_q.push_back('{w[i], (i == n - 1), (t == 3'd4 && i == n - 1)});
    endfunction

    // Inputs are settled at the falling edge, so this sees exactly what the next rising edge will.
    always @(negedge clk) begin
        exp_t e;
        if (m_on) begin
            check("fifo_level", 32'(fifo_level), 32'(m_occ));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
            check("trace_done", 32'(trace_done), 32'(m_done));
            if (stall_prev) begin
                check("stall_valid", 32'(tr_valid), 32'd1);
                check("stall_data", 32'(tr_data), 32'(stall_data));
                check("stall_last", 32'(tr_last), 32'(stall_last));
            end
        end
        if (!rst_n) begin
            exp_q.delete();
            m_occ = 0; m_inum = 0; m_drops = 0;
            m_halt = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
            m_on = 1'b1;
            stall_prev = 1'b0;
        end else if (m_on) begin
            stall_prev = tr_valid && !tr_ready;
            stall_data = tr_data;
            stall_last = tr_last;
            if (tr_valid && tr_ready) begin
                got_q.push_back('{tr_data, tr_last});
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %0h expected nothing", tr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_word", 32'(tr_data), 32'(e.w));
                    check("stream_last", 32'(tr_last), 32'(e.last));
                    if (e.last) begin
                        m_occ--;
                        if (e.halt_end) m_done = 1'b1;
                    end
                end
            end
            if (ret_valid && !m_halt) begin
                if (m_occ < DEPTH) begin
                    model_capture();
                    m_occ++;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
                if (ret_halt) m_halt = 1'b1;
                m_inum = (m_inum + 1) % 512;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ret_valid = 1'b0; ret_pc = 16'd0; ret_reg_we = 1'b0; ret_rd = 4'd0;
        ret_wdata = 16'd0; ret_mem_re = 1'b0; ret_mem_we = 1'b0;
        ret_addr = 16'd0; ret_mdata = 16'd0; ret_halt = 1'b0;
    endtask

    task automatic drive_ev(input logic we, input logic re, input logic mw, input logic hlt,
                            input logic [3:0] rd, input logic [15:0] pc, input logic [15:0] wd,
                            input logic [15:0] addr, input logic [15:0] md);
        ret_valid = 1'b1; ret_reg_we = we; ret_mem_re = re; ret_mem_we = mw; ret_halt = hlt;
        ret_rd = rd; ret_pc = pc; ret_wdata = wd; ret_addr = addr; ret_mdata = md;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tr_valid"}, 32'(tr_valid), 32'd0);
        check({tag, "_tr_data"}, 32'(tr_data), 32'd0);
        check({tag, "_tr_last"}, 32'(tr_last), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        check({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
        check({tag, "_trace_done"}, 32'(trace_done), 32'd0);
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            step();
            c++;
        end
        if (got_q.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d words expected %0d", tag, got_q.size(), n);
        end
    endtask

    typedef struct {
        logic we, re, mw, hlt;
        logic [3:0] rd;
        logic [15:0] pc, wd, addr, md;
        logic toggle;
        int n;
        logic [63:0] words;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // word0 in the low 16 bits; inum counts 0..6 from the reset before the table
        vecs[0] = '{1, 0, 0, 0, 4'd3, 16'h0004, 16'h00AB, 16'h0000, 16'h0000, 0, 3, 64'h0000_00AB_0004_2600};
        vecs[1] = '{1, 1, 0, 0, 4'd5, 16'h0008, 16'h1234, 16'h0040, 16'h0000, 0, 4, 64'h0040_1234_0008_4A01};
        vecs[2] = '{0, 0, 1, 0, 4'd7, 16'h000C, 16'h9999, 16'h0010, 16'hBEEF, 1, 4, 64'hBEEF_0010_000C_6002};
        vecs[3] = '{0, 0, 0, 0, 4'd9, 16'h0010, 16'h7777, 16'h0000, 16'h0000, 0, 2, 64'h0000_0000_0010_0003};
        vecs[4] = '{1, 0, 0, 0, 4'd15, 16'h0014, 16'hFFFF, 16'h0000, 16'h0000, 1, 3, 64'h0000_FFFF_0014_3E04};
        vecs[5] = '{1, 1, 1, 0, 4'd6, 16'h0018, 16'hAAAA, 16'h0100, 16'h5555, 0, 4, 64'h5555_0100_0018_6005};
        vecs[6] = '{0, 1, 0, 0, 4'd2, 16'h001C, 16'h1111, 16'h2222, 16'h0000, 0, 2, 64'h0000_0000_001C_0006};

        drive_idle();
        rst_n = 1'b0;
        tr_ready = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Latency: captured at edge N, header visible after edge N+1.
        drive_ev(1, 0, 0, 0, 4'd1, 16'h0002, 16'h0011, 16'h0, 16'h0);
        step();
        drive_idle();
        check("lat_valid_n", 32'(tr_valid), 32'd0);
        check("lat_level_n", 32'(fifo_level), 32'd1);
        step();
        check("lat_valid_n1", 32'(tr_valid), 32'd1);
        check("lat_hdr_n1", 32'(tr_data), 32'h2200);
        check("lat_last_n1", 32'(tr_last), 32'd0);
        got_q.delete();
        tr_ready = 1'b1;
        wait_words("lat", 3, 20);
        if (got_q.size() >= 3) begin
            check("lat_w1", 32'(got_q[1].w), 32'h0002);
            check("lat_w2", 32'(got_q[2].w), 32'h0011);
            check("lat_last", 32'(got_q[2].last), 32'd1);
        end

        // Directed single-record vectors.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            int c;
            got_q.delete();
            tr_ready = 1'b1;
            drive_ev(vecs[k].we, vecs[k].re, vecs[k].mw, vecs[k].hlt, vecs[k].rd,
                     vecs[k].pc, vecs[k].wd, vecs[k].addr, vecs[k].md);
            step();
            drive_idle();
            c = 0;
            while (got_q.size() < vecs[k].n && c < 100) begin
                step();
                c++;
                if (vecs[k].toggle) tr_ready = ~tr_ready;
            end
            repeat (4) step();
            tr_ready = 1'b1;
            check($sformatf("vec%0d_count", k), 32'(got_q.size()), 32'(vecs[k].n));
            for (int i = 0; i < vecs[k].n && i < got_q.size(); i++) begin
                check($sformatf("vec%0d_w%0d", k, i), 32'(got_q[i].w), 32'(vecs[k].words[16*i +: 16]));
                check($sformatf("vec%0d_last%0d", k, i), 32'(got_q[i].last), 32'(i == vecs[k].n - 1));
            end
        end

        // Overflow: 10 NOPs into a stalled 8-entry FIFO.
        do_reset();
        tr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_ev(0, 0, 0, 0, 4'd0, 16'(i * 4), 16'h0, 16'h0, 16'h0);
            step();
        end
        drive_idle();
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_cnt), 32'd2);
        got_q.delete();
        tr_ready = 1'b1;
        repeat (16) step();
        check("ovf_burst_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 8 && 2 * i + 1 < got_q.size(); i++) begin
            check($sformatf("ovf_hdr%0d", i), 32'(got_q[2*i].w), 32'(i));
            check($sformatf("ovf_pc%0d", i), 32'(got_q[2*i+1].w), 32'(i * 4));
            check($sformatf("ovf_last%0d", i), 32'(got_q[2*i+1].last), 32'd1);
        end
        step();
        check("ovf_idle_valid", 32'(tr_valid), 32'd0);

        // HALT followed by three ignored retires.
        do_reset();
        tr_ready = 1'b1;
        got_q.delete();
        drive_ev(0, 0, 0, 1, 4'd4, 16'h0020, 16'h0, 16'h0, 16'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive_ev(1, 0, 0, 0, 4'd1, 16'h0030, 16'h0, 16'h0, 16'h0);
            step();
        end
        drive_idle();
        check("halt_done_early", 32'(trace_done), 32'd1);
        repeat (5) step();
        check("halt_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() >= 2) begin
            check("halt_hdr", 32'(got_q[0].w), 32'h8000);
            check("halt_pc", 32'(got_q[1].w), 32'h0020);
            check("halt_last", 32'(got_q[1].last), 32'd1);
        end
        check("halt_done", 32'(trace_done), 32'd1);
        check("halt_drops", 32'(drop_cnt), 32'd0);

        // Reset while word 2 of a LOAD is on the bus.
        do_reset();
        tr_ready = 1'b1;
        drive_ev(1, 1, 0, 0, 4'd5, 16'h0A0A, 16'h1234, 16'h0040, 16'h0);
        step();
        drive_idle();
        begin
            int c = 0;
            while (!(tr_valid && tr_data == 16'h0A0A) && c < 20) begin
                step();
                c++;
            end
            check("midrst_reach_pc", 32'(tr_data), 32'h0A0A);
        end
        rst_n = 1'b0;
        step();
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        got_q.delete();
        drive_ev(1, 0, 0, 0, 4'd2, 16'h0050, 16'h00CD, 16'h0, 16'h0);
        step();
        drive_idle();
        wait_words("midrst", 3, 20);
        if (got_q.size() >= 3) begin
            check("midrst_hdr", 32'(got_q[0].w), 32'h2400);
            check("midrst_pc", 32'(got_q[1].w), 32'h0050);
            check("midrst_wd", 32'(got_q[2].w), 32'h00CD);
        end

        // Randomized traffic against the model: light load, then heavy load with drops.
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            int vp = (cyc < 400) ? 25 : 60;
            int rp = (cyc < 400) ? 90 : 50;
            drive_idle();
            if ($urandom_range(0, 99) < vp) begin
                drive_ev(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0,
                         4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            end
            tr_ready = ($urandom_range(0, 99) < rp);
            step();
        end
        drive_idle();
        tr_ready = 1'b1;
        begin
            int c = 0;
            while (exp_q.size() > 0 && c < 300) begin
                step();
                c++;
            end
            check("rand_drained", 32'(exp_q.size()), 32'd0);
        end
        repeat (2) step();
        check("rand_level_end", 32'(fifo_level), 32'd0);
        check("rand_valid_end", 32'(tr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
